// File: rtl/memory_arbiter_if.sv
// Bus bundle between the memory arbiter, its two clients and the memory controller.
// slave = arbiter side, master = client/controller side.
interface memory_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
);
  logic              calib_done;
  logic              wr_rq;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_rq;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_cmd;
  logic              mem_cmd_en;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_data_valid;
  logic              timeout_err;

  modport slave (
    input  calib_done, wr_rq, wr_addr, wr_en, wr_data,
    input  rd_rq, rd_addr, rd_en, mem_rd_data, mem_rd_data_valid,
    output wr_ack, rd_ack, rd_data, rd_data_valid,
    output mem_addr, mem_cmd, mem_cmd_en, mem_wr_data, timeout_err
  );

  modport master (
    output calib_done, wr_rq, wr_addr, wr_en, wr_data,
    output rd_rq, rd_addr, rd_en, mem_rd_data, mem_rd_data_valid,
    input  wr_ack, rd_ack, rd_data, rd_data_valid,
    input  mem_addr, mem_cmd, mem_cmd_en, mem_wr_data, timeout_err
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-client (frame upload / display read) arbiter for one memory controller port.
// Optional ARB_ROUND_ROBIN_EN: alternate on simultaneous requests instead of read priority.
module memory_arbiter #(
  parameter int GUARD_CYCLES = 2,
  parameter int MAX_HOLD     = 64
) (
  input logic             clk,
  input logic             reset,
  memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT_WR, GRANT_RD, GUARD} state_t;

  localparam logic [7:0] HOLD_LAST  = 8'(MAX_HOLD - 1);
  localparam logic [3:0] GUARD_LAST = (GUARD_CYCLES == 0) ? 4'd0 : 4'(GUARD_CYCLES - 1);
  localparam state_t     AFTER_GRANT = (GUARD_CYCLES == 0) ? IDLE : GUARD;

  state_t     state;
  logic [7:0] hold_cnt;
  logic [3:0] guard_cnt;
  logic       wr_lock;
  logic       rd_lock;
  logic       guard_rd;
  logic       wr_ack_r;
  logic       rd_ack_r;
  logic       timeout_r;

  logic       wr_elig;
  logic       rd_elig;
  logic       pick_wr;
  logic       pick_rd;

  // A client forced out by timeout stays ineligible until it drops its request.
  assign wr_elig = bus.wr_rq & ~wr_lock;
  assign rd_elig = bus.rd_rq & ~rd_lock;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_rd;
  assign pick_wr = wr_elig & (~rd_elig | last_rd);
`else
  assign pick_wr = wr_elig & ~rd_elig;
`endif
  assign pick_rd = rd_elig & ~pick_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold_cnt  <= 8'd0;
      guard_cnt <= 4'd0;
      wr_lock   <= 1'b0;
      rd_lock   <= 1'b0;
      guard_rd  <= 1'b0;
      wr_ack_r  <= 1'b0;
      rd_ack_r  <= 1'b0;
      timeout_r <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_rd   <= 1'b1;
`endif
    end else begin
      timeout_r <= 1'b0;
      if (!bus.wr_rq) wr_lock <= 1'b0;
      if (!bus.rd_rq) rd_lock <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.calib_done && pick_wr) begin
            state    <= GRANT_WR;
            wr_ack_r <= 1'b1;
            hold_cnt <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_rd  <= 1'b0;
`endif
          end else if (bus.calib_done && pick_rd) begin
            state    <= GRANT_RD;
            rd_ack_r <= 1'b1;
            hold_cnt <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_rd  <= 1'b1;
`endif
          end
        end

        GRANT_WR: begin
          // Voluntary release wins over a timeout landing on the same cycle.
          if (!bus.wr_rq || hold_cnt == HOLD_LAST) begin
            state     <= AFTER_GRANT;
            guard_cnt <= 4'd0;
            guard_rd  <= 1'b0;
            wr_ack_r  <= 1'b0;
            if (bus.wr_rq) begin
              wr_lock   <= 1'b1;
              timeout_r <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        GRANT_RD: begin
          if (!bus.rd_rq || hold_cnt == HOLD_LAST) begin
            state     <= AFTER_GRANT;
            guard_cnt <= 4'd0;
            guard_rd  <= 1'b1;
            rd_ack_r  <= 1'b0;
            if (bus.rd_rq) begin
              rd_lock   <= 1'b1;
              timeout_r <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        GUARD: begin
          if (guard_cnt == GUARD_LAST) state <= IDLE;
          else                         guard_cnt <= guard_cnt + 4'd1;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Controller command path is a pure mux of the granted client.
  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    bus.mem_cmd     = 1'b0;
    bus.mem_cmd_en  = 1'b0;
    case (state)
      GRANT_WR: begin
        bus.mem_addr    = bus.wr_addr;
        bus.mem_wr_data = bus.wr_data;
        bus.mem_cmd     = 1'b1;
        bus.mem_cmd_en  = bus.wr_en;
      end
      GRANT_RD: begin
        bus.mem_addr    = bus.rd_addr;
        bus.mem_cmd_en  = bus.rd_en;
      end
      default: ;
    endcase
  end

  // Read words still in flight after release are delivered during the guard gap.
  assign bus.rd_data       = bus.mem_rd_data;
  assign bus.rd_data_valid = bus.mem_rd_data_valid &
                             ((state == GRANT_RD) || (state == GUARD && guard_rd));
  assign bus.wr_ack        = wr_ack_r;
  assign bus.rd_ack        = rd_ack_r;
  assign bus.timeout_err   = timeout_r;

endmodule
